// File: rtl/cfg_seq_pkg.sv
// Shared definitions for the cfg register sequencer: state encoding, timeout fill word, width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cfg_seq_pkg;

    // Raw state codes, kept as named constants so debug tooling can decode the state bus
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WR_REQ  = ST_WR_REQ,
        RD_REQ  = ST_RD_REQ,
        RD_WAIT = ST_RD_WAIT,
        DONE    = ST_DONE
    } state_t;

    // Written into a readback slot whose completion never arrived
    localparam logic [31:0] TMO_FILL = 32'hDEAD_BEEF;

    // Bits needed to hold values 0..n-1, never less than 1
    function automatic int clog2(input int n);
        int r = 0;
        int v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cfg_seq_tmo.sv
// Read-completion watchdog: counts cycles while enabled, flags expiry on the TMO_CYC-th cycle.
// Latency: expire is combinational from the count, asserted in the cycle the count is TMO_CYC-1.
// Backpressure: none; the counter holds at expiry until the next clear.
module cfg_seq_tmo #(
    parameter int TMO_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    import cfg_seq_pkg::*;

    localparam int CW = clog2(TMO_CYC);
    localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == LAST);

    // Count wait cycles; clear wins so a fresh read always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cfg_seq_bfm.sv
// Register sequencer: writes every cfg table entry, reads each back into cfg_idt, then flags done.
// Latency: first request 1 cycle after start; writes 1/cycle; one read outstanding at a time.
// Backpressure: req_valid and fields held stable until req_ready; optional readback compare under CFG_SEQ_CMP_EN.
module cfg_seq_bfm #(
    parameter int CFG_NUM = 16,
    parameter int TMO_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*CFG_NUM-1:0] cfg_oaddr,
    input  logic [32*CFG_NUM-1:0] cfg_odt,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_wr,
    output logic [31:0]           req_addr,
    output logic [31:0]           req_data,
    input  logic                  rsp_valid,
    input  logic [31:0]           rsp_data,
    output logic [32*CFG_NUM-1:0] cfg_idt,
    output logic                  casen_test_done,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_cmp,
    output logic [15:0]           err_cnt
);
    import cfg_seq_pkg::*;

    localparam int IDX_W = clog2(CFG_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CFG_NUM - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [31:0]      nxt_addr;
    logic [31:0]      nxt_data;
    logic             tmo_clr;
    logic             tmo_en;
    logic             tmo_exp;
    logic             rd_fire;
    logic             start_ok;
    logic [31:0]      rd_val;

    // Next entry lookup is only consumed when idx is not the last entry
    assign nxt_idx  = idx + 1'b1;
    assign nxt_addr = cfg_oaddr[32'(nxt_idx) * 32 +: 32];
    assign nxt_data = cfg_odt[32'(nxt_idx) * 32 +: 32];

    assign start_ok = ((state == IDLE) || (state == DONE)) && start;
    assign tmo_clr  = (state == RD_REQ) && req_ready;
    assign tmo_en   = (state == RD_WAIT);
    // A completion in the expiry cycle is taken as a normal response
    assign rd_fire  = (state == RD_WAIT) && (rsp_valid || tmo_exp);
    assign rd_val   = rsp_valid ? rsp_data : TMO_FILL;

    cfg_seq_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_exp)
    );

    // Sequencer FSM: all request and status outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            req_valid       <= 1'b0;
            req_wr          <= 1'b0;
            req_addr        <= '0;
            req_data        <= '0;
            cfg_idt         <= '0;
            casen_test_done <= 1'b0;
            busy            <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= WR_REQ;
                        idx             <= '0;
                        req_valid       <= 1'b1;
                        req_wr          <= 1'b1;
                        req_addr        <= cfg_oaddr[31:0];
                        req_data        <= cfg_odt[31:0];
                        busy            <= 1'b1;
                        casen_test_done <= 1'b0;
                        err_timeout     <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (req_ready) begin
                        if (idx == LAST_IDX) begin
                            state    <= RD_REQ;
                            idx      <= '0;
                            req_wr   <= 1'b0;
                            req_addr <= cfg_oaddr[31:0];
                            req_data <= '0;
                        end else begin
                            idx      <= nxt_idx;
                            req_addr <= nxt_addr;
                            req_data <= nxt_data;
                        end
                    end
                end
                RD_REQ: begin
                    if (req_ready) begin
                        state     <= RD_WAIT;
                        req_valid <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (rd_fire) begin
                        cfg_idt[32'(idx) * 32 +: 32] <= rd_val;
                        if (!rsp_valid) begin
                            err_timeout <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state           <= DONE;
                            casen_test_done <= 1'b1;
                            busy            <= 1'b0;
                        end else begin
                            state     <= RD_REQ;
                            idx       <= nxt_idx;
                            req_valid <= 1'b1;
                            req_addr  <= nxt_addr;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CFG_SEQ_CMP_EN
    logic [31:0] cur_data;

    assign cur_data = cfg_odt[32'(idx) * 32 +: 32];

    // Readback compare: a timeout slot or differing data both count as a miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cmp <= 1'b0;
            err_cnt <= '0;
        end else if (start_ok) begin
            err_cmp <= 1'b0;
            err_cnt <= '0;
        end else if (rd_fire && (!rsp_valid || (rsp_data != cur_data))) begin
            err_cmp <= 1'b1;
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_start_ok;

    assign unused_start_ok = start_ok;
    assign err_cmp         = 1'b0;
    assign err_cnt         = '0;
`endif

endmodule

// File: tb/tb_cfg_seq_bfm.sv
// Bench for cfg_seq_bfm: random tables, echoing responder, request scoreboard and readback model.
// Latency: n/a.
// Backpressure: req_ready driven either constantly high or randomly.
module tb_cfg_seq_bfm;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [32*N-1:0] cfg_oaddr;
    logic [32*N-1:0] cfg_odt;
    logic            req_valid;
    logic            req_ready;
    logic            req_wr;
    logic [31:0]     req_addr;
    logic [31:0]     req_data;
    logic            rsp_valid;
    logic [31:0]     rsp_data;
    logic [32*N-1:0] cfg_idt;
    logic            casen_test_done;
    logic            busy;
    logic            err_timeout;
    logic            err_cmp;
    logic [15:0]     err_cnt;

    cfg_seq_bfm #(.CFG_NUM(N), .TMO_CYC(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_oaddr       (cfg_oaddr),
        .cfg_odt         (cfg_odt),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_wr          (req_wr),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .cfg_idt         (cfg_idt),
        .casen_test_done (casen_test_done),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .err_cmp         (err_cmp),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        exp_q[$];
    req_t        exp_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cyc[$];
    logic [31:0] addr_tab[N];
    logic [31:0] data_tab[N];
    logic [31:0] mem[logic [31:0]];
    int          tmo_idx = -1;
    int          exp_idx = -1;
    int          bad_idx = -1;
    int          rd_seen = 0;
    bit          rand_ready = 0;
    bit          prev_stall = 0;
    logic [64:0] prev_req;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_tables(input bit zero0);
        for (int k = 0; k < N; k++) begin
            addr_tab[k] = ($urandom & 32'hFFFF_FF00) | 32'(k * 4);
            data_tab[k] = $urandom;
        end
        if (zero0) data_tab[0] = 32'h0;
        for (int k = 0; k < N; k++) begin
            cfg_oaddr[k*32 +: 32] = addr_tab[k];
            cfg_odt[k*32 +: 32]   = data_tab[k];
        end
    endtask

    always @(posedge clk) cyc++;

    // Ready generator
    always @(posedge clk) begin
        #1 req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: hold-stability check and scoreboard pop on every handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check("hold_stable", {req_valid, req_wr, req_addr, req_data}, {1'b1, prev_req});
            if (req_valid && req_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got %h expected none", {req_wr, req_addr, req_data});
                end else begin
                    exp_e = exp_q.pop_front();
                    check("req", {req_wr, req_addr, req_data}, exp_e);
                end
                if (req_wr) begin
                    mem[req_addr] = req_data;
                    wr_cyc.push_back(cyc);
                end
            end
            prev_stall = req_valid && !req_ready;
            prev_req   = {req_wr, req_addr, req_data};
        end
    end

    // Responder: one thread per accepted read
    task automatic spawn(input int e, input logic [31:0] a);
        fork
            begin
                int          ee = e;
                int          d;
                logic [31:0] v;
                v = mem.exists(a) ? mem[a] : 32'hBAD0_0000;
                d = 3;
                if (ee == exp_idx) d = TMO;
                if (ee == tmo_idx) begin
                    d = TMO + 1;
                    v = 32'h1234_5678;
                end
                if (ee == bad_idx) v = v ^ 32'h1;
                @(posedge clk);
                repeat (d - 1) @(posedge clk);
                #1 rsp_valid = 1'b1;
                rsp_data = v;
                @(posedge clk);
                #1 rsp_valid = 1'b0;
                rsp_data = $urandom;
            end
        join_none
    endtask

    always @(negedge clk) begin
        if (rst_n && req_valid && req_ready && !req_wr) begin
            spawn(rd_seen, req_addr);
            rd_seen++;
        end
    end

    task automatic issue(input int ti, input int ei, input int bi, input bit rnd);
        tmo_idx    = ti;
        exp_idx    = ei;
        bad_idx    = bi;
        rand_ready = rnd;
        rd_seen    = 0;
        wr_cyc.delete();
        for (int k = 0; k < N; k++) exp_q.push_back({1'b1, addr_tab[k], data_tab[k]});
        for (int k = 0; k < N; k++) exp_q.push_back({1'b0, addr_tab[k], 32'h0});
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("first_req_valid", {req_valid, busy, casen_test_done}, {1'b1, 1'b1, 1'b0});
    endtask

    task automatic run_seq(input int ti, input int ei, input int bi, input bit rnd, input bit chk_b2b);
        int n;
        int nerr;
        issue(ti, ei, bi, rnd);
        n = 0;
        while (!casen_test_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!casen_test_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 2000 cycles");
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            logic [31:0] ev;
            ev = data_tab[k];
            if (k == ti) ev = 32'hDEAD_BEEF;
            if (k == bi) ev = data_tab[k] ^ 32'h1;
            check($sformatf("slot%0d", k), cfg_idt[k*32 +: 32], ev);
        end
        check("status", {casen_test_done, busy, err_timeout}, {1'b1, 1'b0, (ti >= 0)});
        check("queue_empty", exp_q.size(), 0);
`ifdef CFG_SEQ_CMP_EN
        nerr = ((ti >= 0) ? 1 : 0) + ((bi >= 0) ? 1 : 0);
`else
        nerr = 0;
`endif
        check("err_cmp_cnt", {err_cmp, err_cnt}, {(nerr != 0), 16'(nerr)});
        if (chk_b2b) begin
            check("b2b_count", wr_cyc.size(), N);
            if (wr_cyc.size() == N) check("b2b_span", wr_cyc[N-1] - wr_cyc[0], N - 1);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {req_valid, req_wr, busy, casen_test_done, err_timeout, err_cmp}, 0);
        check({tag, "_addr_data"}, {req_addr, req_data}, 0);
        check({tag, "_idt_lo"}, cfg_idt[63:0], 0);
        check({tag, "_idt_hi"}, cfg_idt[127:64], 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        cfg_oaddr = '0;
        cfg_odt   = '0;
        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: ready always high, 3-cycle echo
        load_tables(1'b0);
        run_seq(-1, -1, -1, 1'b0, 1'b1);
        // 2: random backpressure, same tables, restart from DONE
        run_seq(-1, -1, -1, 1'b1, 1'b0);
        // 3: read 2 never answered in time (late reply must be ignored)
        load_tables(1'b0);
        run_seq(2, -1, -1, 1'b1, 1'b0);
        // 4: read 1 answered in the exact expiry cycle
        load_tables(1'b0);
        run_seq(-1, 1, -1, 1'b0, 1'b0);

        // 5: reset pulse during RD_WAIT of entry 1, then a clean rerun
        load_tables(1'b0);
        issue(-1, -1, -1, 1'b0);
        n = 0;
        while (rd_seen < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (rd_seen < 2) begin
            checks++;
            errors++;
            $display("FAIL rd1_wait: got reads=%0d expected 2", rd_seen);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (6) @(posedge clk);
        exp_q.delete();
        #2 rst_n = 1'b1;
        run_seq(-1, -1, -1, 1'b0, 1'b1);

        // 6: entry 0 written as 0, read back as 1
        load_tables(1'b1);
        run_seq(-1, -1, 0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
